// File: rtl/issue_window_scheduler_if.sv
// Enqueue/issue handshake bundle for issue_window_scheduler.
//   master : upstream/downstream side. It drives enq_vld, enq_instr and iss_stall,
//            and receives enq_rdy, iss_vld and iss_instr.
//   slave  : the scheduler.
// Instruction packing (24 b): {branch[2:0], op[3:0], des[3:0], s1[3:0], s2[3:0], ime[4:0]}
interface issue_window_scheduler_if #(
   parameter int ENQ_W   = 2,
   parameter int ISSUE_W = 2
) ();
   logic [ENQ_W-1:0]          enq_vld;
   logic [ENQ_W-1:0][23:0]    enq_instr;
   logic                      enq_rdy;
   logic                      iss_stall;
   logic [ISSUE_W-1:0]        iss_vld;
   logic [ISSUE_W-1:0][23:0]  iss_instr;

   modport master (output enq_vld, enq_instr, iss_stall,
                   input  enq_rdy, iss_vld, iss_instr);
   modport slave  (input  enq_vld, enq_instr, iss_stall,
                   output enq_rdy, iss_vld, iss_instr);
endinterface

// File: rtl/issue_window_scheduler.sv
// issue_window_scheduler: circular window of decoded instructions. Each cycle it
// issues the oldest in-order prefix of up to ISSUE_W hazard-free entries. A
// 16-entry busy scoreboard holds in-flight destinations, and writeback ports
// clear it.
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   bus          : enqueue/issue handshake (issue_window_scheduler_if.slave)
//   wb_vld/wb_reg: writeback clear ports for busy bits
//   flush        : discard every window entry (the scoreboard is kept)
//   win_count    : number of occupied entries
//   perf_issued/perf_stall : performance counters, present only when
//                  ISSQ_PERF_CNT_EN is defined (otherwise tied to 0)
module issue_window_scheduler #(
   parameter int DEPTH   = 8,
   parameter int ENQ_W   = 2,
   parameter int ISSUE_W = 2,
   parameter int WB_W    = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   issue_window_scheduler_if.slave     bus,
   input  logic [WB_W-1:0]             wb_vld,
   input  logic [WB_W-1:0][3:0]        wb_reg,
   input  logic                        flush,
   output logic [$clog2(DEPTH):0]      win_count,
   output logic [31:0]                 perf_issued,
   output logic [31:0]                 perf_stall
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // Ready means a full ENQ_W group fits. Same-cycle issue earns no credit.
   localparam logic [CW-1:0] ENQ_LIM = CW'(DEPTH - ENQ_W);

   typedef struct packed {
      logic [2:0] branch;
      logic [3:0] op;
      logic [3:0] des;
      logic [3:0] s1;
      logic [3:0] s2;
      logic [4:0] ime;
   } instr_t;

   instr_t [DEPTH-1:0]   win;
   logic   [PW-1:0]      head, tail;
   logic   [CW-1:0]      count;
   logic   [15:0]        busy, busy_nxt;

   instr_t [ISSUE_W-1:0] cand;
   logic   [ISSUE_W-1:0] elig, iss_v;
   logic                 chain_ok, hz, gate, rdy, enq_fire;
   logic   [CW-1:0]      iss_n, enq_n;

   // Slot k looks at the entry k places past head. The pointer wraps naturally.
   always_comb begin
      for (int k = 0; k < ISSUE_W; k++)
         cand[k] = win[head + PW'(k)];
   end

   // A slot is eligible only if every lower slot is eligible. A branch goes only
   // in slot 0 and closes the group. Lower-slot destinations block RAW and WAW
   // hazards within the group.
   always_comb begin
      elig     = '0;
      chain_ok = 1'b1;
      hz       = 1'b0;
      for (int k = 0; k < ISSUE_W; k++) begin
         hz = busy[cand[k].s1] | busy[cand[k].s2];
         if (k != 0 && cand[k].branch != 3'd0) hz = 1'b1;
         for (int j = 0; j < k; j++) begin
            if (cand[j].des == cand[k].s1 || cand[j].des == cand[k].s2 ||
                cand[j].des == cand[k].des) hz = 1'b1;
            if (cand[j].branch != 3'd0) hz = 1'b1;
         end
         chain_ok = chain_ok & ~hz & (CW'(k) < count);
         elig[k]  = chain_ok;
      end
   end

   assign gate        = ~bus.iss_stall & ~flush;
   assign iss_v       = elig & {ISSUE_W{gate}};
   assign bus.iss_vld = iss_v;

   always_comb begin
      bus.iss_instr = '0;
      for (int k = 0; k < ISSUE_W; k++)
         if (iss_v[k]) bus.iss_instr[k] = cand[k];
   end

   assign rdy         = (count <= ENQ_LIM);
   assign bus.enq_rdy = rdy;
   assign enq_fire    = rdy & bus.enq_vld[0] & ~flush;
   assign win_count   = count;

   always_comb begin
      iss_n = '0;
      enq_n = '0;
      for (int k = 0; k < ISSUE_W; k++)
         iss_n = iss_n + CW'(iss_v[k]);
      for (int i = 0; i < ENQ_W; i++)
         if (enq_fire && bus.enq_vld[i]) enq_n = enq_n + CW'(1);
   end

   // Clears are applied first, so a same-cycle set of the same register wins.
   always_comb begin
      busy_nxt = busy;
      for (int w = 0; w < WB_W; w++)
         if (wb_vld[w]) busy_nxt[wb_reg[w]] = 1'b0;
      for (int k = 0; k < ISSUE_W; k++)
         if (iss_v[k]) busy_nxt[cand[k].des] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         busy  <= '0;
      end else begin
         if (flush) begin
            head  <= tail;
            count <= '0;
         end else begin
            head  <= head + PW'(iss_n);
            tail  <= tail + PW'(enq_n);
            count <= count + enq_n - iss_n;
         end
         busy <= busy_nxt;
      end
   end

   // Window payload needs no reset. Slots are only read under count qualification.
   always_ff @(posedge clk) begin
      if (enq_fire)
         for (int i = 0; i < ENQ_W; i++)
            if (bus.enq_vld[i]) win[tail + PW'(i)] <= bus.enq_instr[i];
   end

`ifdef ISSQ_PERF_CNT_EN
   logic [31:0] cnt_iss, cnt_stl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_iss <= '0;
         cnt_stl <= '0;
      end else if (flush) begin
         cnt_iss <= '0;
         cnt_stl <= '0;
      end else begin
         cnt_iss <= cnt_iss + 32'(iss_n);
         if (count != '0 && !iss_v[0]) cnt_stl <= cnt_stl + 32'd1;
      end
   end

   assign perf_issued = cnt_iss;
   assign perf_stall  = cnt_stl;
`else
   assign perf_issued = '0;
   assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_issue_window_scheduler.sv
// Directed bench for issue_window_scheduler. Each instruction the bench expects
// to be accepted is pushed to exp_q when driven. A negedge monitor pops exp_q for
// every issued slot and checks program order.
module tb_issue_window_scheduler;
   localparam int DEPTH = 8, ENQ_W = 2, ISSUE_W = 2, WB_W = 2;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   flush = 1'b0;
   logic [WB_W-1:0]        wb_vld = '0;
   logic [WB_W-1:0][3:0]   wb_reg = '0;
   logic [3:0]             win_count;
   logic [31:0]            perf_issued, perf_stall;
   int                     compared = 0, mismatched = 0;
   logic [23:0]            exp_q[$];
   logic [23:0]            exp_i;
   logic [ISSUE_W-1:0]     pv;

   issue_window_scheduler_if #(.ENQ_W(ENQ_W), .ISSUE_W(ISSUE_W)) bus ();

   issue_window_scheduler #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .ISSUE_W(ISSUE_W), .WB_W(WB_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .wb_vld(wb_vld), .wb_reg(wb_reg),
      .flush(flush), .win_count(win_count), .perf_issued(perf_issued), .perf_stall(perf_stall));

   always #5 clk = ~clk;

   function automatic logic [23:0] mk(input logic [2:0] br, input logic [3:0] des, s1, s2);
      return {br, 4'ha, des, s1, s2, {1'b1, des}};
   endfunction

   function automatic logic [23:0] chain(input int i);
      return mk(3'd0, 4'(i + 1), (i == 0) ? 4'd9 : 4'(i), 4'd9);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cv(input string t, input logic [ISSUE_W-1:0] e); chk(t, 32'(bus.iss_vld), 32'(e)); endtask
   task automatic cc(input string t, input int e); chk(t, 32'(win_count), 32'(e)); endtask
   task automatic cr(input string t, input logic e); chk(t, 32'(bus.enq_rdy), 32'(e)); endtask
   task automatic tick(); @(posedge clk); #1; endtask
   task automatic mid(); @(negedge clk); endtask

   task automatic idle();
      bus.enq_vld = '0;
      wb_vld      = '0;
      flush       = 1'b0;
   endtask

   task automatic enq(input logic [1:0] v, input logic [23:0] a, b, input bit push);
      bus.enq_vld      = v;
      bus.enq_instr[0] = a;
      bus.enq_instr[1] = b;
      if (push) begin
         if (v[0]) exp_q.push_back(a);
         if (v[1]) exp_q.push_back(b);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      bus.iss_stall = 1'b0;
      bus.enq_instr = '0;
      exp_q.delete();
      mid();
      cr("rst_rdy", 1'b1);
      cv("rst_vld", 2'b00);
      chk("rst_instr", 32'(bus.iss_instr[0] | bus.iss_instr[1]), 32'h0);
      cc("rst_cnt", 0);
      chk("rst_perf", perf_issued | perf_stall, 32'h0);
      tick();
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: issued slots in order against exp_q, idle slots carry
   // zero, and iss_vld is always a contiguous prefix.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < ISSUE_W; k++) begin
            compared++;
            if (bus.iss_vld[k]) begin
               exp_i = (exp_q.size() != 0) ? exp_q.pop_front() : 24'bx;
               assert (bus.iss_instr[k] === exp_i) else begin
                  mismatched++;
                  $error("FAIL sb_slot%0d: observed %h, expected %h", k, bus.iss_instr[k], exp_i);
               end
            end else begin
               assert (bus.iss_instr[k] === 24'h0) else begin
                  mismatched++;
                  $error("FAIL idle_instr%0d: observed %h, expected 0", k, bus.iss_instr[k]);
               end
            end
         end
         pv = bus.iss_vld + 1'b1;
         compared++;
         assert ((pv & bus.iss_vld) === '0) else begin
            mismatched++;
            $error("FAIL vld_prefix: observed %b, expected contiguous prefix", bus.iss_vld);
         end
      end
   end

   initial begin
      logic [23:0] alu, br;

      // Two independent instructions dual-issue one cycle after enqueue.
      do_reset();
      enq(2'b11, mk(0, 1, 2, 3), mk(0, 4, 5, 6), 1);
      mid(); cr("t1_rdy", 1'b1); cv("t1_c0", 2'b00);
      tick(); idle();
      mid(); cv("t1_c1", 2'b11); cc("t1_c1_cnt", 2);
      tick();
      mid(); cv("t1_c2", 2'b00); cc("t1_c2_cnt", 0);

      // RAW on r1. A same-cycle wb of r1 loses to the set. The issue comes the cycle after a real wb.
      do_reset();
      enq(2'b11, mk(0, 1, 2, 3), mk(0, 7, 1, 0), 1);
      tick(); idle(); wb_vld = 2'b01; wb_reg[0] = 4'd1;
      mid(); cv("t2_c1", 2'b01);
      tick(); idle();
      mid(); cv("t2_c2", 2'b00); cc("t2_c2_cnt", 1);
      tick(); wb_vld = 2'b10; wb_reg[0] = 4'd0; wb_reg[1] = 4'd1;
      mid(); cv("t2_c3_nobypass", 2'b00);
      tick(); idle();
      mid(); cv("t2_c4", 2'b01);
      tick();
      mid(); cc("t2_c5_cnt", 0);

      // A branch closes the group, in either order.
      alu = mk(3'd0, 4'd2, 4'd8, 4'd9);
      br  = mk(3'b001, 4'd0, 4'd4, 4'd0);
      do_reset();
      enq(2'b11, alu, br, 1);
      tick(); idle();
      mid(); cv("t3a_c1", 2'b01);
      tick();
      mid(); cv("t3a_c2", 2'b01);
      tick();
      mid(); cc("t3a_cnt", 0);
      do_reset();
      enq(2'b11, br, alu, 1);
      tick(); idle();
      mid(); cv("t3b_c1", 2'b01);
      tick();
      mid(); cv("t3b_c2", 2'b01);
      tick();
      mid(); cc("t3b_cnt", 0);

      // Fill with a dependency chain from head=2, then drain through the pointer wrap.
      do_reset();
      enq(2'b11, mk(0, 10, 11, 12), mk(0, 13, 14, 15), 1);
      tick(); idle();
      mid(); cv("t4_pre", 2'b11);
      tick();
      bus.iss_stall = 1'b1;
      for (int g = 0; g < 4; g++) begin
         enq(2'b11, chain(2 * g), chain(2 * g + 1), 1);
         mid(); cr("t4_fill_rdy", 1'b1); cc("t4_fill_cnt", 2 * g);
         tick();
      end
      enq(2'b11, mk(0, 14, 14, 14), mk(0, 15, 14, 14), 0);
      mid(); cr("t4_full_rdy", 1'b0); cc("t4_full_cnt", 8); cv("t4_stall", 2'b00);
      tick(); idle(); bus.iss_stall = 1'b0;
      mid(); cc("t4_noovf_cnt", 8); cv("t4_c0", 2'b01);
      tick();
      for (int k = 1; k < 8; k++) begin
         wb_reg[0] = 4'(k);
         wb_reg[1] = 4'(k);
         wb_vld    = (k % 2 == 1) ? 2'b01 : 2'b10;
         mid(); cv("t4_blk", 2'b00); cc("t4_drain_cnt", 8 - k); cr("t4_drain_rdy", (8 - k) <= 6);
         tick(); wb_vld = '0;
         mid(); cv("t4_iss", 2'b01);
         tick();
      end
      mid(); cc("t4_empty", 0);

      // Flush drops the window and the same-cycle enqueue. Nothing flushed issues later.
      do_reset();
      bus.iss_stall = 1'b1;
      enq(2'b11, mk(0, 1, 2, 3), mk(0, 4, 5, 6), 1);
      tick();
      enq(2'b11, mk(0, 7, 8, 9), mk(0, 10, 11, 12), 1);
      tick();
      bus.iss_stall = 1'b0;
      flush = 1'b1;
      enq(2'b11, mk(0, 13, 14, 15), mk(0, 2, 3, 5), 0);
      exp_q.delete();
      mid(); cc("t5_pre_cnt", 4); cv("t5_flush_vld", 2'b00);
      tick(); idle();
      mid(); cc("t5_post_cnt", 0); cv("t5_post_vld", 2'b00); cr("t5_rdy", 1'b1);
      tick();
      mid(); cv("t5_quiet", 2'b00);
      tick();
      enq(2'b11, mk(0, 5, 6, 7), mk(0, 8, 9, 10), 1);
      mid(); cv("t5_g_c0", 2'b00);
      tick(); idle();
      mid(); cv("t5_g_c1", 2'b11);
      tick();

      // Counter scenario: 3 issued, 2 blocked cycles.
      do_reset();
      enq(2'b11, mk(0, 1, 2, 3), mk(0, 5, 1, 2), 1);
      tick();
      enq(2'b01, mk(0, 6, 7, 8), 24'h0, 1);
      mid(); cv("t6_c1", 2'b01);
      tick(); idle();
      mid(); cv("t6_c2", 2'b00);
      tick(); wb_vld = 2'b01; wb_reg[0] = 4'd1;
      mid(); cv("t6_c3", 2'b00);
      tick(); idle();
      mid(); cv("t6_c4", 2'b11);
      tick();
      mid();
`ifdef ISSQ_PERF_CNT_EN
      chk("perf_issued", perf_issued, 32'd3);
      chk("perf_stall", perf_stall, 32'd2);
`else
      chk("perf_issued", perf_issued, 32'd0);
      chk("perf_stall", perf_stall, 32'd0);
`endif

      tick(); tick();
      mid(); chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/issue_window_scheduler.md
Name: issue_window_scheduler

Overview:
- Parametrised successor of the dual-issue stage-1 logic. Merges queueing, dependency checking and slot steering into one block.
- Buffers decoded instructions in a circular window of DEPTH entries.
- Each cycle, issues the oldest in-order prefix of up to ISSUE_W hazard-free instructions.
- Tracks in-flight destinations in a 16-entry register scoreboard that writeback ports clear.

Parameters:
- DEPTH, 8, window entries; power of two, range 4..32.
- ENQ_W, 2, instructions accepted per cycle; 1..4, ENQ_W <= DEPTH.
- ISSUE_W, 2, issue slots; 1..4.
- WB_W, 2, writeback clear ports.

Ports:
- clk, input, 1, clock, rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- enq_vld, input, ENQ_W, per-lane enqueue valid; must be a contiguous prefix from lane 0.
- enq_instr, input, ENQ_W*24, lane i = {branch[2:0], op[3:0], des[3:0], s1[3:0], s2[3:0], ime[4:0]}.
- enq_rdy, output, 1, window can accept a full ENQ_W group this cycle.
- iss_stall, input, 1, downstream stall; no issue while high.
- iss_vld, output, ISSUE_W, per-slot issue valid; always a contiguous prefix.
- iss_instr, output, ISSUE_W*24, issued instruction per slot, same packing as enq_instr.
- wb_vld, input, WB_W, writeback valid.
- wb_reg, input, WB_W*4, register whose busy bit is cleared.
- flush, input, 1, discard all window entries.
- win_count, output, clog2(DEPTH)+1, occupied entries.
- perf_issued, output, 32, issued-instruction counter (optional feature).
- perf_stall, output, 32, blocked-cycle counter (optional feature).

Behaviour:
- Reset (rst_n low, async): head=tail=0, count=0, scoreboard all clear, counters 0.
  - Outputs during reset: enq_rdy=1, iss_vld=0, iss_instr=0, win_count=0.
- enq_rdy = (DEPTH - count) >= ENQ_W, computed from registered count only. An issue in the same cycle gives no credit; full-window enqueue+issue is therefore never possible.
- Enqueue fires when enq_rdy && enq_vld[0].
  - Lanes with enq_vld set are written at tail, tail+1, ... modulo DEPTH. tail advances by popcount(enq_vld).
  - enq_vld asserted while enq_rdy=0 is ignored; upstream must hold its data.
- Issue is combinational from registered window state. Minimum enqueue-to-issue latency is 1 cycle.
- Slot k (0..ISSUE_W-1) examines entry head+k. Slot k is eligible iff all of the following hold:
  - k < count;
  - all slots below k are eligible;
  - s1 and s2 are not busy in the registered scoreboard;
  - s1, s2 and des differ from des of every lower slot (intra-group RAW/WAW);
  - if branch != 0, then k == 0;
  - no lower slot holds a branch (a branch terminates the group).
- Regardless of eligibility: iss_vld = 0 when iss_stall=1 or flush=1. iss_instr is 0 in invalid slots.
- On the clock edge, head and count update by the number of issued slots and the number of enqueued lanes.
- Scoreboard:
  - Each issued des sets its busy bit.
  - Each wb_vld lane clears wb_reg.
  - If set and clear hit the same register in one cycle, set wins.
  - Writeback is not bypassed: the register reads busy until the following cycle.
- flush:
  - Next cycle: head=tail, count=0. Same-cycle enqueue is dropped and nothing issues.
  - Scoreboard unaffected; in-flight writebacks still clear it.
- Pointer wrap: head/tail are clog2(DEPTH)-bit values and wrap naturally. count distinguishes full from empty.
- Reset mid-operation: state returns to reset values immediately. In-flight writebacks after reset are harmless clears.

Optional Feature:
- Macro ISSQ_PERF_CNT_EN.
- Defined:
  - perf_issued increments by popcount(iss_vld) each cycle.
  - perf_stall increments by 1 in each cycle with count > 0 and iss_vld[0] = 0.
  - Both wrap at 2^32 and clear on reset and flush.
- Undefined: no counter flops; perf_issued and perf_stall are tied to 0.

Test Plan:
- Reset then enqueue {des=1,s1=2,s2=3} and {des=4,s1=5,s2=6} in one cycle -> next cycle iss_vld=2'b11 with both instructions in order; cycle after, win_count=0.
- Enqueue {des=1,s1=2,s2=3} and {des=7,s1=1,s2=0} -> slot 0 issues alone. Slot 1 stays blocked (r1 busy) until wb_vld=1, wb_reg=1; it issues in the cycle after the writeback.
- Enqueue {ALU des=2} then {branch=3'b001, s1=4} -> first cycle ALU only, branch issues next cycle in slot 0. Reversed order -> branch issues alone, ALU the cycle after.
- Fill DEPTH=8 with a long dependency chain -> enq_rdy=0 at count>=7. Drain via writebacks across a pointer wrap -> FIFO order preserved, count never exceeds 8.
- Enqueue 4 entries, assert flush with enq_vld=2'b11 -> next cycle win_count=0, iss_vld=0, no later issue of any flushed entry.
- With ISSQ_PERF_CNT_EN: 3 issued, 2 blocked cycles -> perf_issued=3, perf_stall=2. Without the macro -> both read 0.
